// File: rtl/wb_stage.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : wb_stage                                                       |
// | Purpose  : Writeback stage. Selects ALU, load or link data and issues a   |
// |            single-cycle registered write to the register file.            |
// | Options  : WB_FWD_EN - registered pending-load hazard outputs for decode. |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module wb_stage #(
  parameter int DW  = 32,
  parameter int PCW = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           MEM_valid,
  output logic           MEM_ready,
  input  logic           MEM_regwrite,
  input  logic           MEM_memtoreg,
  input  logic           MEM_link,
  input  logic [2:0]     MEM_ws,
  input  logic [DW-1:0]  MEM_alu_result,
  input  logic [PCW-1:0] MEM_pc,
  input  logic [DW-1:0]  dmem_rdata,
  input  logic           dmem_rvalid,
  input  logic           WB_flush,
  output logic           WB_regwrite,
  output logic [2:0]     WB_ws,
  output logic [DW-1:0]  WB_wd,
  output logic [15:0]    retired_cnt,
  output logic           fwd_busy,
  output logic [2:0]     fwd_ws
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_LOAD = 2'd1,
    S_WRITE     = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            regwrite_q, regwrite_d;
  logic [2:0]      ws_q, ws_d;
  logic [DW-1:0]   wd_q, wd_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      pend_ws_q, pend_ws_d;
  logic            w_accept;
  logic [DW-1:0]   w_link_wd;

  assign MEM_ready = !reset && (state_q != S_WAIT_LOAD);
  assign w_accept  = MEM_valid && MEM_ready;

  // Link address is widened before the increment so PC 'hFF yields 'h100.
  assign w_link_wd = {{(DW-PCW){1'b0}}, MEM_pc} + {{(DW-1){1'b0}}, 1'b1};

  always_comb begin
    state_d    = state_q;
    regwrite_d = 1'b0;
    ws_d       = ws_q;
    wd_d       = wd_q;
    cnt_d      = cnt_q;
    pend_ws_d  = pend_ws_q;
    case (state_q)
      S_WAIT_LOAD: begin
        if (WB_flush) begin
          state_d = S_IDLE;
        end else if (dmem_rvalid) begin
          state_d    = S_WRITE;
          regwrite_d = 1'b1;
          ws_d       = pend_ws_q;
          wd_d       = dmem_rdata;
          cnt_d      = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (w_accept) begin
          if (!MEM_regwrite) begin
            cnt_d = cnt_q + 16'd1;
          end else if (MEM_memtoreg) begin
            state_d   = S_WAIT_LOAD;
            pend_ws_d = MEM_ws;
          end else begin
            state_d    = S_WRITE;
            regwrite_d = 1'b1;
            ws_d       = MEM_ws;
            wd_d       = MEM_link ? w_link_wd : MEM_alu_result;
            cnt_d      = cnt_q + 16'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      regwrite_q <= 1'b0;
      ws_q       <= 3'd0;
      wd_q       <= '0;
      cnt_q      <= 16'd0;
      pend_ws_q  <= 3'd0;
    end else begin
      state_q    <= state_d;
      regwrite_q <= regwrite_d;
      ws_q       <= ws_d;
      wd_q       <= wd_d;
      cnt_q      <= cnt_d;
      pend_ws_q  <= pend_ws_d;
    end
  end

  assign WB_regwrite = regwrite_q;
  assign WB_ws       = ws_q;
  assign WB_wd       = wd_q;
  assign retired_cnt = cnt_q;

`ifdef WB_FWD_EN
  logic       fwd_busy_q;
  logic [2:0] fwd_ws_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_busy_q <= 1'b0;
      fwd_ws_q   <= 3'd0;
    end else begin
      fwd_busy_q <= (state_d == S_WAIT_LOAD);
      fwd_ws_q   <= (state_d == S_WAIT_LOAD) ? pend_ws_d : 3'd0;
    end
  end

  assign fwd_busy = fwd_busy_q;
  assign fwd_ws   = fwd_ws_q;
`else
  assign fwd_busy = 1'b0;
  assign fwd_ws   = 3'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_wb_stage                                                    |
// | Purpose  : Self-checking bench for wb_stage with a behavioural model.     |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module tb_wb_stage;
  localparam int DW  = 32;
  localparam int PCW = 8;
`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           MEM_valid = 1'b0;
  logic           MEM_ready;
  logic           MEM_regwrite = 1'b0;
  logic           MEM_memtoreg = 1'b0;
  logic           MEM_link = 1'b0;
  logic [2:0]     MEM_ws = 3'd0;
  logic [DW-1:0]  MEM_alu_result = '0;
  logic [PCW-1:0] MEM_pc = '0;
  logic [DW-1:0]  dmem_rdata = '0;
  logic           dmem_rvalid = 1'b0;
  logic           WB_flush = 1'b0;
  logic           WB_regwrite;
  logic [2:0]     WB_ws;
  logic [DW-1:0]  WB_wd;
  logic [15:0]    retired_cnt;
  logic           fwd_busy;
  logic [2:0]     fwd_ws;

  int checks = 0;
  int failures = 0;

  // Reference model: what the register file should observe after each edge.
  bit            m_wait;
  logic [2:0]    m_pend;
  bit            m_we;
  logic [2:0]    m_ws;
  logic [DW-1:0] m_wd;
  logic [15:0]   m_cnt;

  always #5 clk = ~clk;

  wb_stage #(.DW(DW), .PCW(PCW)) dut (
    .clk(clk), .reset(reset),
    .MEM_valid(MEM_valid), .MEM_ready(MEM_ready),
    .MEM_regwrite(MEM_regwrite), .MEM_memtoreg(MEM_memtoreg), .MEM_link(MEM_link),
    .MEM_ws(MEM_ws), .MEM_alu_result(MEM_alu_result), .MEM_pc(MEM_pc),
    .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid), .WB_flush(WB_flush),
    .WB_regwrite(WB_regwrite), .WB_ws(WB_ws), .WB_wd(WB_wd),
    .retired_cnt(retired_cnt), .fwd_busy(fwd_busy), .fwd_ws(fwd_ws)
  );

  // Drive one cycle of stimulus, advance the model, and return #1 after the edge.
  task automatic step(input bit rst, input bit v, input bit rw, input bit mtr, input bit lnk,
                      input logic [2:0] ws, input logic [DW-1:0] alu, input logic [PCW-1:0] pc,
                      input bit rv, input logic [DW-1:0] rd, input bit fl);
    bit acc;
    reset = rst; MEM_valid = v; MEM_regwrite = rw; MEM_memtoreg = mtr; MEM_link = lnk;
    MEM_ws = ws; MEM_alu_result = alu; MEM_pc = pc;
    dmem_rvalid = rv; dmem_rdata = rd; WB_flush = fl;
    acc  = v && !m_wait && !rst;
    m_we = 1'b0;
    if (rst) begin
      m_wait = 1'b0; m_pend = 3'd0; m_ws = 3'd0; m_wd = '0; m_cnt = 16'd0;
    end else if (m_wait) begin
      if (fl) m_wait = 1'b0;
      else if (rv) begin
        m_wait = 1'b0; m_we = 1'b1; m_ws = m_pend; m_wd = rd; m_cnt = m_cnt + 16'd1;
      end
    end else if (acc) begin
      if (!rw) m_cnt = m_cnt + 16'd1;
      else if (mtr) begin
        m_wait = 1'b1; m_pend = ws;
      end else begin
        m_we = 1'b1; m_ws = ws; m_cnt = m_cnt + 16'd1;
        m_wd = lnk ? (32'(pc) + 32'd1) : alu;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 32'd9, '0, 1'b0, '0, 1'b0);
    checks++;
    if (WB_regwrite !== 1'b0 || WB_ws !== 3'd0 || WB_wd !== 32'd0 || retired_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_outputs: got we=%b ws=%0d wd=%h cnt=%0d, want 0/0/0/0", WB_regwrite, WB_ws, WB_wd, retired_cnt);
    end
    checks++;
    if (fwd_busy !== 1'b0 || fwd_ws !== 3'd0 || MEM_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_fwd_ready: got busy=%b fws=%0d ready=%b, want 0/0/0", fwd_busy, fwd_ws, MEM_ready);
    end
    idle();
    checks++;
    if (MEM_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset: got %b, want 1", MEM_ready);
    end
  endtask

  task automatic test_alu();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 32'd77, 8'h10, 1'b0, '0, 1'b0);
    checks++;
    if (WB_regwrite !== 1'b1 || WB_ws !== 3'd3 || WB_wd !== 32'd77 || retired_cnt !== 16'd1) begin
      failures++;
      $display("FAIL alu_write: got we=%b ws=%0d wd=%0d cnt=%0d, want 1/3/77/1", WB_regwrite, WB_ws, WB_wd, retired_cnt);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0, 1'b1, 32'h5555, 1'b0);
    checks++;
    if (WB_regwrite !== 1'b0 || WB_ws !== 3'd3 || WB_wd !== 32'd77 || retired_cnt !== 16'd1) begin
      failures++;
      $display("FAIL alu_hold: got we=%b ws=%0d wd=%0d cnt=%0d, want 0/3/77/1", WB_regwrite, WB_ws, WB_wd, retired_cnt);
    end
  endtask

  task automatic test_load();
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 32'd1, '0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (MEM_ready !== 1'b0 || WB_regwrite !== 1'b0) begin
        failures++;
        $display("FAIL load_wait_%0d: got ready=%b we=%b, want 0/0", k, MEM_ready, WB_regwrite);
      end
      checks++;
      if (fwd_busy !== FWD || fwd_ws !== (FWD ? 3'd5 : 3'd0)) begin
        failures++;
        $display("FAIL load_fwd_%0d: got busy=%b fws=%0d, want %b/%0d", k, fwd_busy, fwd_ws, FWD, FWD ? 5 : 0);
      end
      if (k < 2) step(1'b0, k[0], 1'b1, 1'b0, 1'b0, 3'd1, 32'h99, '0, 1'b0, '0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0, 1'b1, 32'hDEAD, 1'b0);
    checks++;
    if (WB_regwrite !== 1'b1 || WB_ws !== 3'd5 || WB_wd !== 32'hDEAD || MEM_ready !== 1'b1 || fwd_busy !== 1'b0) begin
      failures++;
      $display("FAIL load_write: got we=%b ws=%0d wd=%h ready=%b busy=%b, want 1/5/dead/1/0", WB_regwrite, WB_ws, WB_wd, MEM_ready, fwd_busy);
    end
    idle();
    checks++;
    if (WB_regwrite !== 1'b0 || retired_cnt !== 16'd2) begin
      failures++;
      $display("FAIL load_single_pulse: got we=%b cnt=%0d, want 0/2", WB_regwrite, retired_cnt);
    end
  endtask

  task automatic test_link();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd7, 32'h12345678, 8'hFF, 1'b0, '0, 1'b0);
    checks++;
    if (WB_regwrite !== 1'b1 || WB_ws !== 3'd7 || WB_wd !== 32'h100) begin
      failures++;
      $display("FAIL link_write: got we=%b ws=%0d wd=%h, want 1/7/00000100", WB_regwrite, WB_ws, WB_wd);
    end
  endtask

  task automatic test_flush();
    logic [15:0] c0;
    c0 = m_cnt;
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 32'd4, 8'h01, 1'b0, '0, 1'b0);
    idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0, 1'b1, 32'hBEEF, 1'b1);
    checks++;
    if (WB_regwrite !== 1'b0 || MEM_ready !== 1'b1 || retired_cnt !== c0 || WB_wd !== 32'h100) begin
      failures++;
      $display("FAIL flush_wins: got we=%b ready=%b cnt=%0d wd=%h, want 0/1/%0d/00000100", WB_regwrite, MEM_ready, retired_cnt, WB_wd, c0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0, 1'b1, 32'hBEEF, 1'b0);
    checks++;
    if (WB_regwrite !== 1'b0 || retired_cnt !== c0) begin
      failures++;
      $display("FAIL rvalid_ignored: got we=%b cnt=%0d, want 0/%0d", WB_regwrite, retired_cnt, c0);
    end
  endtask

  task automatic test_reset_in_wait();
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4, '0, '0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0, 1'b1, 32'hCAFE, 1'b0);
    checks++;
    if (WB_regwrite !== 1'b0 || WB_ws !== 3'd0 || WB_wd !== 32'd0 || retired_cnt !== 16'd0 || fwd_busy !== 1'b0 || fwd_ws !== 3'd0) begin
      failures++;
      $display("FAIL reset_in_wait: got we=%b ws=%0d wd=%h cnt=%0d busy=%b fws=%0d, want all 0", WB_regwrite, WB_ws, WB_wd, retired_cnt, fwd_busy, fwd_ws);
    end
    idle();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 32'h1234, '0, 1'b0, '0, 1'b0);
    checks++;
    if (WB_regwrite !== 1'b1 || WB_ws !== 3'd6 || WB_wd !== 32'h1234 || retired_cnt !== 16'd1) begin
      failures++;
      $display("FAIL after_reset_alu: got we=%b ws=%0d wd=%h cnt=%0d, want 1/6/1234/1", WB_regwrite, WB_ws, WB_wd, retired_cnt);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'(k), 32'(100 + k), '0, 1'b0, '0, 1'b0);
      checks++;
      if (WB_regwrite !== 1'b1 || WB_ws !== 3'(k) || WB_wd !== 32'(100 + k) || MEM_ready !== 1'b1) begin
        failures++;
        $display("FAIL back_to_back_%0d: got we=%b ws=%0d wd=%0d ready=%b, want 1/%0d/%0d/1", k, WB_regwrite, WB_ws, WB_wd, MEM_ready, k, 100 + k);
      end
    end
    idle();
    checks++;
    if (WB_regwrite !== 1'b0 || retired_cnt !== m_cnt) begin
      failures++;
      $display("FAIL back_to_back_end: got we=%b cnt=%0d, want 0/%0d", WB_regwrite, retired_cnt, m_cnt);
    end
  endtask

  task automatic test_counter_wrap();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 65535; k++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 32'd1, '0, 1'b0, '0, 1'b0);
    checks++;
    if (retired_cnt !== 16'hFFFF || WB_regwrite !== 1'b0) begin
      failures++;
      $display("FAIL count_max: got cnt=%h we=%b, want ffff/0", retired_cnt, WB_regwrite);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 32'd1, '0, 1'b0, '0, 1'b0);
    checks++;
    if (retired_cnt !== 16'h0000) begin
      failures++;
      $display("FAIL count_wrap: got cnt=%h, want 0000", retired_cnt);
    end
  endtask

  task automatic test_random();
    bit rst, v, rw, mtr, lnk, rv, fl;
    logic [2:0] ws;
    logic [PCW-1:0] pc;
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(99, 0) == 0);
      v   = ($urandom_range(9, 0) < 7);
      rw  = ($urandom_range(9, 0) < 8);
      mtr = ($urandom_range(9, 0) < 3);
      lnk = ($urandom_range(9, 0) < 3);
      rv  = ($urandom_range(9, 0) < 4);
      fl  = ($urandom_range(9, 0) < 1);
      ws  = 3'($urandom_range(7, 0));
      pc  = ($urandom_range(7, 0) == 0) ? 8'hFF : 8'($urandom_range(255, 0));
      step(rst, v, rw, mtr, lnk, ws, 32'($urandom), pc, rv, 32'($urandom), fl);
      checks++;
      if (WB_regwrite !== m_we || WB_ws !== m_ws || WB_wd !== m_wd) begin
        failures++;
        $display("FAIL rand_write[%0d]: got we=%b ws=%0d wd=%h, want %b/%0d/%h", i, WB_regwrite, WB_ws, WB_wd, m_we, m_ws, m_wd);
      end
      checks++;
      if (retired_cnt !== m_cnt || MEM_ready !== (!rst && !m_wait)) begin
        failures++;
        $display("FAIL rand_cnt_ready[%0d]: got cnt=%0d ready=%b, want %0d/%b", i, retired_cnt, MEM_ready, m_cnt, !rst && !m_wait);
      end
      checks++;
      if (fwd_busy !== (FWD && m_wait) || fwd_ws !== ((FWD && m_wait) ? m_pend : 3'd0)) begin
        failures++;
        $display("FAIL rand_fwd[%0d]: got busy=%b fws=%0d, want %b/%0d", i, fwd_busy, fwd_ws, FWD && m_wait, (FWD && m_wait) ? m_pend : 3'd0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_link();
    test_flush();
    test_reset_in_wait();
    test_back_to_back();
    test_counter_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
